neuron_mac: RTL
===============

Name: neuron_mac

Overview:
- Upstream neighbour of the ReLU activation stage. Computes one neuron's pre-activation: a sum of signed fixed-point input × weight products plus bias.
- Emits a 2*dataWidth-wide saturated sum with a one-cycle valid pulse, which feeds the ReLU's x input directly.
- Holds its own weight memory, loadable at run time, and a bias register.

Parameters:
- dataWidth, 16, width of input samples, weights and bias (signed two's complement).
- weightIntWidth, 4, integer bits of the fixed-point format. Carried through for the downstream ReLU; it does not change arithmetic here.
- numInputs, 784, inputs per vector (weights per neuron); must be ≥2.
- addrWidth, $clog2(numInputs), weight address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x_valid  in  1  input sample valid.
- x  in  dataWidth  signed input sample.
- w_wen  in  1  weight write enable.
- w_addr  in  addrWidth  weight write address.
- w_data  in  dataWidth  signed weight write data.
- b_wen  in  1  bias write enable.
- b_data  in  2*dataWidth  signed bias, already aligned to product format.
- sum  out  2*dataWidth  signed saturated pre-activation.
- sum_valid  out  1  one-cycle pulse; sum is valid in this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - sum=0 and sum_valid=0.
  - Input counter, accumulator and all pipeline valids cleared.
  - Bias register cleared to 0.
  - Weight memory contents are not reset.
- Input counter cnt (0..numInputs-1):
  - Each x_valid=1 cycle accepts x, reads weight[cnt] and increments cnt.
  - At numInputs-1, cnt wraps to 0 and the sample is tagged "last".
- Gaps: x_valid may deassert between samples for any number of cycles; state holds.
- Pipeline (sample accepted in cycle T):
  - T: synchronous weight read issued at address cnt; x, first and last tags registered.
  - T+1: signed product x*w (2*dataWidth bits, exact, no overflow) registered.
  - T+2: accumulate. If tagged first, acc <= product; else acc <= sat(acc + product).
  - T+3: if tagged last, sum <= sat(acc + bias).
  - T+4: sum_valid=1 for exactly one cycle.
- Saturation rule sat(a+b): if a and b have equal sign and the result sign differs, clamp.
  - Positive overflow clamps to 0x7FFF…F.
  - Negative overflow clamps to 0x800…0.
  - The rule applies to every accumulate and to the bias add.
- Back-to-back vectors: the first sample of the next vector may arrive in the cycle after the last sample. The first tag restarts acc, so no bubble is needed.
- sum holds its value between pulses.
- Bias: b_wen writes the bias register immediately. The value in effect at the T+3 add of the last sample is the one used.
- Weight writes:
  - Allowed at any time, with a 1-cycle write.
  - Read and write to the same address in the same cycle returns the OLD data (read-first).
  - Writes during a vector affect only reads issued in later cycles.
- No back-pressure: the consumer must accept every sum_valid pulse.
- Reset mid-vector: the partial vector is discarded. No sum_valid is produced for it. The next accepted sample is element 0.

Decomposition:
- Shared package nn_pkg:
  - Fixed-point constants: DATA_W, WEIGHT_INT_W, ACC_W = 2*DATA_W.
  - Saturated signed add function sat_add.
  - ACC_MAX and ACC_MIN constants. ReLU and later layers reuse these.
- Sub-module weight_mem:
  - Single-port-write / single-port-read synchronous RAM, depth numInputs, width dataWidth, read-first.
  - Instantiated once.

Test Plan:
1. numInputs=4; weights 1,1,1,1; bias=0; x=1,2,3,4 on consecutive cycles starting at T -> sum=10 with sum_valid high only at T+7 (last sample at T+3, plus 4).
2. numInputs=4; all weights and x = 0x7FFF; bias=1 -> partial sums 0x3FFF0001, 0x7FFE0002, then saturated -> sum=0x7FFFFFFF; bias add stays clamped.
3. numInputs=4; x=0x8000, w=0x7FFF (product 0xC0008000); bias=-1 -> sum=0x80000000.
4. Two vectors back-to-back: x=1,1,1,1 then 2,2,2,2, weights 1, with random x_valid gaps in the second -> sum=4 then sum=8; two distinct one-cycle pulses; no cross-contamination.
5. Reset asserted after 2 of 4 samples, then released, then full vector 1,2,3,4 -> no pulse for the aborted vector; next sum=10; bias reads 0 unless rewritten.
6. Write weight[0]=5 in the same cycle x_valid reads address 0 (old weight 1, x=1, others 0) -> sum=1. Next vector with x=1,0,0,0 -> sum=5.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the neural-network datapath blocks.
// The accumulator format is twice the sample width, so products are exact
// and only the running sums need saturation.
package nn_pkg;

    localparam int DATA_W       = 16;
    localparam int WEIGHT_INT_W = 4;
    localparam int ACC_W        = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed add that clamps instead of wrapping: overflow is only possible
    // when both operands share a sign and the result sign flips.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W-1:0] s;
        s = a + b;
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]))
            return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        return s;
    endfunction

endpackage

// File: rtl/weight_mem.sv
// Synchronous weight RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module weight_mem #(
    parameter int depth = 784,
    parameter int width = 16,
    parameter int aw    = $clog2(depth)
) (
    input  logic                    clk,
    input  logic                    wen,
    input  logic [aw-1:0]           waddr,
    input  logic signed [width-1:0] wdata,
    input  logic                    ren,
    input  logic [aw-1:0]           raddr,
    output logic signed [width-1:0] rdata
);

    logic signed [width-1:0] mem [depth];

    // Storage update; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wen)
            mem[waddr] <= wdata;
    end

    // Registered read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (ren)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/neuron_mac.sv
// One neuron's pre-activation: saturated sum of x*w products plus bias.
// Five-stage flow per sample: read/tag, multiply, accumulate, bias add on the
// last element, then a one-cycle valid pulse alongside a held sum.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4,
    parameter int numInputs      = 784,
    parameter int addrWidth      = $clog2(numInputs)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          x_valid,
    input  logic signed [dataWidth-1:0]   x,
    input  logic                          w_wen,
    input  logic [addrWidth-1:0]          w_addr,
    input  logic signed [dataWidth-1:0]   w_data,
    input  logic                          b_wen,
    input  logic signed [2*dataWidth-1:0] b_data,
    output logic signed [2*dataWidth-1:0] sum,
    output logic                          sum_valid
);

    // The saturation helper is shared at the package width.
    if (dataWidth != DATA_W)
        $error("neuron_mac: dataWidth must equal nn_pkg::DATA_W");
    if (numInputs < 2)
        $error("neuron_mac: numInputs must be at least 2");
    if (weightIntWidth >= dataWidth)
        $error("neuron_mac: weightIntWidth must leave fraction bits");

    localparam logic [addrWidth-1:0] LAST_IDX = addrWidth'(numInputs - 1);

    logic [addrWidth-1:0]        cnt;
    logic                        v0, first0, last0;
    logic signed [dataWidth-1:0] x_q;
    logic signed [dataWidth-1:0] w_rd;
    logic                        v1, first1, last1;
    logic signed [ACC_W-1:0]     prod;
    logic                        v2, last2;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     bias;

    weight_mem #(
        .depth (numInputs),
        .width (dataWidth),
        .aw    (addrWidth)
    ) u_weight_mem (
        .clk   (clk),
        .wen   (w_wen),
        .waddr (w_addr),
        .wdata (w_data),
        .ren   (x_valid),
        .raddr (cnt),
        .rdata (w_rd)
    );

    // Element counter and stage-0 capture of the sample and its position tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            v0     <= 1'b0;
            first0 <= 1'b0;
            last0  <= 1'b0;
            x_q    <= '0;
        end else begin
            v0 <= x_valid;
            if (x_valid) begin
                x_q    <= x;
                first0 <= (cnt == '0);
                last0  <= (cnt == LAST_IDX);
                cnt    <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            end
        end
    end

    // Exact signed product of the sample and the weight read last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            prod   <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                prod   <= ACC_W'(x_q) * ACC_W'(w_rd);
                first1 <= first0;
                last1  <= last0;
            end
        end
    end

    // Accumulate; the first element of a vector overwrites the old total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            acc   <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                last2 <= last1;
                acc   <= first1 ? prod : sat_add(acc, prod);
            end
        end
    end

    // Bias register, written directly from the configuration port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bias <= '0;
        else if (b_wen)
            bias <= b_data;
    end

    // Final bias add on the last element; sum holds until the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= v2 && last2;
            if (v2 && last2)
                sum <= sat_add(acc, bias);
        end
    end

endmodule
